// File: rtl/irq_sched_pkg.sv
// Shared types and constants for the periodic interrupt scheduler.
// The state encoding is fixed so that state values stay stable across revisions.
package irq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // 8 kHz tick at 50 MHz
    localparam int DEF_PERIOD_CYC = 6250;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping around to the start of the vector.
module rr_arbiter
    import irq_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          valid
);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/irq_tick_sched.sv
// Multi-channel periodic interrupt scheduler: programmable tick timers set pending
// bits, a round-robin arbiter grants one at a time, and the MCU acknowledges by edge.
module irq_tick_sched
    import irq_sched_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = DEF_PERIOD_CYC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(N_SRC)-1:0]   cfg_idx,
    input  logic [CNT_W-1:0]           cfg_period,
    input  logic [N_SRC-1:0]           en_mask,
    input  logic                       ack,
    output logic                       ei_req,
    output logic [$clog2(N_SRC)-1:0]   irq_id,
    output logic [N_SRC-1:0]           pending,
    output logic [N_SRC-1:0]           overrun
);

    localparam int                IW       = idx_width(N_SRC);
    localparam logic [CNT_W-1:0]  DEF_P    = CNT_W'(DEF_PERIOD);
    localparam logic [IW-1:0]     LAST_IDX = IW'(N_SRC - 1);

    logic [CNT_W-1:0] cnt_reg     [N_SRC];
    logic [CNT_W-1:0] cnt_next    [N_SRC];
    logic [CNT_W-1:0] period_reg  [N_SRC];
    logic [CNT_W-1:0] period_next [N_SRC];

    logic [N_SRC-1:0] tick;
    logic [N_SRC-1:0] cfg_hit;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] pending_reg;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] overrun_reg;
    logic [N_SRC-1:0] overrun_next;

    state_t           state_reg;
    logic             ei_req_reg;
    logic [IW-1:0]    irq_id_reg;
    logic [IW-1:0]    rr_ptr_reg;
    logic             ack_q_reg;
    logic             ack_rise;
    logic             withdraw;
    logic [IW-1:0]    arb_grant;
    logic             arb_valid;

    assign ack_rise = ack & ~ack_q_reg;
    assign withdraw = (state_reg == REQ) && cfg_we && (cfg_idx == irq_id_reg);

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_chan
            logic active;
            logic at_end;

            assign cfg_hit[gi] = cfg_we && (cfg_idx == IW'(gi));
            assign active      = en_mask[gi] && (period_reg[gi] != '0);
            assign at_end      = (cnt_reg[gi] == period_reg[gi] - CNT_W'(1));
            // A reconfigured channel restarts cleanly, so its tick is dropped this cycle
            assign tick[gi]    = active && at_end && !cfg_hit[gi];
            assign ack_clr[gi] = (state_reg == REQ) && ack_rise && (irq_id_reg == IW'(gi));

            assign period_next[gi] = cfg_hit[gi] ? cfg_period : period_reg[gi];
            assign cnt_next[gi]    = (cfg_hit[gi] || !active || at_end) ? '0
                                   : cnt_reg[gi] + CNT_W'(1);

            // A fresh tick outranks the ack-clear so the new event is not lost
            assign pending_next[gi] = cfg_hit[gi] ? 1'b0
                                    : tick[gi]    ? 1'b1
                                    : ack_clr[gi] ? 1'b0
                                    : pending_reg[gi];
            assign overrun_next[gi] = cfg_hit[gi] ? 1'b0
                                    : (tick[gi] && pending_reg[gi] && !ack_clr[gi]) ? 1'b1
                                    : overrun_reg[gi];
        end
    endgenerate

    assign eligible = pending_reg & en_mask & ~cfg_hit;

    rr_arbiter #(
        .N  (N_SRC),
        .IW (IW)
    ) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_reg[i]    <= '0;
                period_reg[i] <= DEF_P;
            end
            pending_reg <= '0;
            overrun_reg <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_reg[i]    <= cnt_next[i];
                period_reg[i] <= period_next[i];
            end
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
        end
    end

    // ack resets high so an ack line held through reset is not seen as an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            ei_req_reg <= 1'b0;
            irq_id_reg <= '0;
            rr_ptr_reg <= '0;
            ack_q_reg  <= 1'b1;
        end else begin
            ack_q_reg <= ack;
            case (state_reg)
                IDLE: begin
                    if (arb_valid) begin
                        irq_id_reg <= arb_grant;
                        ei_req_reg <= 1'b1;
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    if (withdraw) begin
                        ei_req_reg <= 1'b0;
                        state_reg  <= RELEASE;
                    end else if (ack_rise) begin
                        ei_req_reg <= 1'b0;
                        rr_ptr_reg <= (irq_id_reg == LAST_IDX) ? '0 : irq_id_reg + IW'(1);
                        state_reg  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    ei_req_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign ei_req  = ei_req_reg;
    assign irq_id  = irq_id_reg;
    assign pending = pending_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_irq_tick_sched.sv
// Directed bench for irq_tick_sched: timers, round-robin order, ack handshake,
// overrun, reconfiguration and reset behaviour with hand-computed expectations.
`timescale 1ns/1ps
module tb_irq_tick_sched;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [15:0] cfg_period;
    logic [3:0]  en_mask;
    logic        ack;
    logic        ei_req;
    logic [1:0]  irq_id;
    logic [3:0]  pending;
    logic [3:0]  overrun;

    int n_checks = 0;
    int n_fail   = 0;

    irq_tick_sched #(
        .N_SRC      (4),
        .CNT_W      (16),
        .DEF_PERIOD (6250)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_period (cfg_period),
        .en_mask    (en_mask),
        .ack        (ack),
        .ei_req     (ei_req),
        .irq_id     (irq_id),
        .pending    (pending),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are sampled 1 ns after the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        cfg_we  = 1'b0;
        cfg_idx = '0;
        cfg_period = '0;
        en_mask = '0;
        ack     = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input int per);
        cfg_we     = 1'b1;
        cfg_idx    = 2'(idx);
        cfg_period = 16'(per);
        step(1);
        cfg_we     = 1'b0;
    endtask

    // Pulse ack, then expect the next grant to be exp_id
    task automatic ack_and_expect(input int exp_id);
        ack = 1'b1;
        step(1);
        check("ack_drop", 32'(ei_req), 32'd0);
        ack = 1'b0;
        step(2);
        check("regrant_req", 32'(ei_req), 32'd1);
        check("regrant_id", 32'(irq_id), 32'(exp_id));
    endtask

    initial begin
        int seen;
        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_period = '0; en_mask = '0; ack = 1'b0;

        // Reset state
        do_reset();
        check("rst_ei_req", 32'(ei_req), 32'd0);
        check("rst_irq_id", 32'(irq_id), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // 1: ch0 period 10, tick on 10th cycle, grant one cycle later
        do_reset();
        cfg_write(0, 10);
        en_mask = 4'b0001;
        step(9);
        check("t1_no_tick_yet", 32'(pending), 32'h0);
        step(1);
        check("t1_pending", 32'(pending), 32'h1);
        check("t1_req_lag", 32'(ei_req), 32'd0);
        step(1);
        check("t1_ei_req", 32'(ei_req), 32'd1);
        check("t1_irq_id", 32'(irq_id), 32'd0);
        ack = 1'b1;
        step(1);
        check("t1_ack_drop", 32'(ei_req), 32'd0);
        check("t1_ack_clear", 32'(pending), 32'h0);
        ack = 1'b0;

        // 2: all four pending together, round-robin order incl. wrap
        do_reset();
        for (int c = 0; c < 4; c++) cfg_write(c, 40);
        en_mask = 4'hF;
        step(40);
        check("t2_all_pending", 32'(pending), 32'hF);
        step(1);
        check("t2_first_req", 32'(ei_req), 32'd1);
        check("t2_first_id", 32'(irq_id), 32'd0);
        ack_and_expect(1);
        ack_and_expect(2);
        step(34);
        check("t2_second_ticks", 32'(pending), 32'hF);
        check("t2_overrun", 32'(overrun), 32'hC);
        check("t2_still_id2", 32'(irq_id), 32'd2);
        ack_and_expect(3);
        ack_and_expect(0);
        ack_and_expect(1);
        ack = 1'b1;
        step(1);
        check("t2_last_drop", 32'(ei_req), 32'd0);
        ack = 1'b0;
        step(2);
        check("t2_drained", 32'(pending), 32'h0);
        check("t2_idle", 32'(ei_req), 32'd0);

        // 3: ack held high consumes exactly one grant
        do_reset();
        cfg_write(0, 8);
        en_mask = 4'b0001;
        step(8);
        check("t3_pending", 32'(pending), 32'h1);
        step(1);
        check("t3_req", 32'(ei_req), 32'd1);
        ack = 1'b1;
        step(1);
        check("t3_drop", 32'(ei_req), 32'd0);
        seen = 0;
        for (int k = 0; k < 19; k++) begin
            step(1);
            if (ei_req) seen++;
        end
        check("t3_no_regrant", 32'(seen), 32'd0);
        check("t3_repending", 32'(pending), 32'h1);
        ack = 1'b0;
        step(2);
        check("t3_after_low", 32'(ei_req), 32'd1);

        // 4: overrun on 2nd tick, cfg write to granted channel withdraws and clears
        do_reset();
        cfg_write(1, 3);
        en_mask = 4'b0010;
        step(3);
        check("t4_pending", 32'(pending), 32'h2);
        check("t4_no_ovr", 32'(overrun), 32'h0);
        step(1);
        check("t4_id", 32'(irq_id), 32'd1);
        step(2);
        check("t4_overrun", 32'(overrun), 32'h2);
        cfg_write(1, 3);
        check("t4_withdraw", 32'(ei_req), 32'd0);
        check("t4_pend_clr", 32'(pending), 32'h0);
        check("t4_ovr_clr", 32'(overrun), 32'h0);
        step(2);
        check("t4_cnt_restart", 32'(pending), 32'h0);
        step(1);
        check("t4_tick_after", 32'(pending), 32'h2);

        // 5: tick on granted ch2 in the same cycle as ack rise
        do_reset();
        cfg_write(2, 6);
        en_mask = 4'b0100;
        step(6);
        check("t5_pending", 32'(pending), 32'h4);
        step(1);
        check("t5_id", 32'(irq_id), 32'd2);
        step(4);
        ack = 1'b1;
        step(1);
        check("t5_drop", 32'(ei_req), 32'd0);
        check("t5_kept", 32'(pending), 32'h4);
        check("t5_no_ovr", 32'(overrun), 32'h0);
        ack = 1'b0;
        step(2);
        check("t5_regrant", 32'(ei_req), 32'd1);
        check("t5_regrant_id", 32'(irq_id), 32'd2);

        // 6a: period 0 never ticks
        do_reset();
        cfg_write(3, 0);
        en_mask = 4'b1000;
        step(20);
        check("t6_period0", 32'(pending), 32'h0);

        // 6b: reset while requesting; periods return to default
        do_reset();
        cfg_write(0, 4);
        en_mask = 4'b0001;
        step(5);
        check("t6_req", 32'(ei_req), 32'd1);
        ack   = 1'b1;
        reset = 1'b1;
        step(1);
        check("t6_rst_req", 32'(ei_req), 32'd0);
        check("t6_rst_pend", 32'(pending), 32'h0);
        reset = 1'b0;
        step(6249);
        check("t6_def_before", 32'(pending), 32'h0);
        step(1);
        check("t6_def_tick", 32'(pending), 32'h1);
        step(1);
        check("t6_def_req", 32'(ei_req), 32'd1);
        step(3);
        check("t6_held_ack", 32'(ei_req), 32'd1);
        ack = 1'b0;
        step(1);
        ack = 1'b1;
        step(1);
        check("t6_ack_edge", 32'(ei_req), 32'd0);
        ack = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
